// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file that serves pointer writes, data writes and multi-byte reads.
// Define I2C_TGT_AUTOINC_EN to auto-increment the register pointer after each data byte.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h29,
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              bus_wr_valid,
    output logic [ADDR_W-1:0] bus_wr_addr,
    output logic [7:0]        bus_wr_data,
    output logic              busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t            state_r;
    logic              scl_meta_r, scl_sync_r, scl_hist_r;
    logic              sda_meta_r, sda_sync_r, sda_hist_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              rw_r;
    // ACK states: ACK already driven; RACK: master ACK sampled
    logic              phase_r;
    logic [7:0]        regs_r [NUM_REGS];

    logic              scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]        rx_byte_s, rd_byte_s;
    logic [ADDR_W-1:0] ptr_next_s;

    assign scl_rise_s = scl_sync_r & ~scl_hist_r;
    assign scl_fall_s = ~scl_sync_r & scl_hist_r;
    assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
    assign rx_byte_s  = {shift_r[6:0], sda_sync_r};
    assign rd_byte_s  = regs_r[ptr_r];

`ifdef I2C_TGT_AUTOINC_EN
    assign ptr_next_s = ptr_r + ADDR_W'(1'b1);
`else
    assign ptr_next_s = ptr_r;
`endif

    // Pad synchronizers with a history stage; idle bus level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
        end
    end

    // Protocol FSM: samples on SCL rise, changes sda_oe only on SCL fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            ptr_r        <= '0;
            rw_r         <= 1'b0;
            phase_r      <= 1'b0;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            bus_wr_valid <= 1'b0;
            bus_wr_addr  <= '0;
            bus_wr_data  <= 8'h00;
        end else begin
            bus_wr_valid <= 1'b0;
            if (stop_s) begin
                state_r <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_s) begin
                state_r   <= ADDR;
                bit_cnt_r <= 3'd7;
                sda_oe    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            if (bit_cnt_r == 3'd0) begin
                                phase_r <= 1'b0;
                                if (rx_byte_s[7:1] == DEV_ADDR) begin
                                    rw_r    <= rx_byte_s[0];
                                    busy    <= 1'b1;
                                    state_r <= ADDR_ACK;
                                end else begin
                                    busy    <= 1'b0;
                                    state_r <= IDLE;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!phase_r) begin
                                sda_oe  <= 1'b1;
                                phase_r <= 1'b1;
                            end else if (rw_r) begin
                                // Snapshot the byte so host writes cannot disturb it mid-transfer
                                shift_r   <= {rd_byte_s[6:0], 1'b0};
                                sda_oe    <= ~rd_byte_s[7];
                                bit_cnt_r <= 3'd7;
                                state_r   <= RDATA;
                            end else begin
                                sda_oe    <= 1'b0;
                                bit_cnt_r <= 3'd7;
                                state_r   <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            if (bit_cnt_r == 3'd0) begin
                                ptr_r   <= rx_byte_s[ADDR_W-1:0];
                                phase_r <= 1'b0;
                                state_r <= PTR_ACK;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!phase_r) begin
                                sda_oe  <= 1'b1;
                                phase_r <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                bit_cnt_r <= 3'd7;
                                state_r   <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            if (bit_cnt_r == 3'd0) begin
                                bus_wr_valid <= 1'b1;
                                bus_wr_addr  <= ptr_r;
                                bus_wr_data  <= rx_byte_s;
                                ptr_r        <= ptr_next_s;
                                phase_r      <= 1'b0;
                                state_r      <= WDATA_ACK;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd0) begin
                                sda_oe  <= 1'b0;
                                phase_r <= 1'b0;
                                state_r <= RACK;
                            end else begin
                                sda_oe    <= ~shift_r[7];
                                shift_r   <= {shift_r[6:0], 1'b0};
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise_s) begin
                            ptr_r <= ptr_next_s;
                            if (sda_sync_r) begin
                                state_r <= IDLE;
                            end else begin
                                phase_r <= 1'b1;
                            end
                        end else if (scl_fall_s && phase_r) begin
                            shift_r   <= {rd_byte_s[6:0], 1'b0};
                            sda_oe    <= ~rd_byte_s[7];
                            bit_cnt_r <= 3'd7;
                            state_r   <= RDATA;
                        end
                    end
                    default: begin
                        sda_oe  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Register file: the bus write is applied last so it wins a same-address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            if (host_we) begin
                regs_r[host_addr] <= host_wdata;
            end
            if (bus_wr_valid) begin
                regs_r[bus_wr_addr] <= bus_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-level I2C master tasks checked against an array/pointer model.
module tb_i2c_target_regfile;
    localparam int         ADDR_W   = 5;
    localparam int         NUM_REGS = 32;
    localparam logic [6:0] DEV      = 7'h29;
    localparam int         Q        = 6;
`ifdef I2C_TGT_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              scl_in;
    logic              sda_in;
    logic              m_sda_low;
    logic              sda_oe;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              bus_wr_valid;
    logic [ADDR_W-1:0] bus_wr_addr;
    logic [7:0]        bus_wr_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        model_regs [NUM_REGS];
    int                model_ptr;
    logic [7:0]        wbuf [8];
    logic [7:0]        rbuf [8];

    int                wr_cnt = 0;
    int                oe_cnt = 0;
    logic [ADDR_W-1:0] cap_addr [256];
    logic [7:0]        cap_data [256];

    i2c_target_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .bus_wr_valid(bus_wr_valid),
        .bus_wr_addr (bus_wr_addr),
        .bus_wr_data (bus_wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Open-drain bus: low if either side pulls
    assign sda_in = ~(m_sda_low | sda_oe);

    // Capture bus write pulses and count cycles with SDA driven by the target
    always @(negedge clk) begin
        if (bus_wr_valid) begin
            cap_addr[wr_cnt[7:0]] <= bus_wr_addr;
            cap_data[wr_cnt[7:0]] <= bus_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (sda_oe) begin
            oe_cnt <= oe_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        scl_in = 1'b1;    wait_q();
        m_sda_low = 1'b1; wait_q();
        scl_in = 1'b0;    wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_q();
        scl_in = 1'b1;    wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl_in = 1'b1;  wait_q(); wait_q();
        scl_in = 1'b0;  wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl_in = 1'b1;    wait_q();
        b = sda_in;       wait_q();
        scl_in = 1'b0;    wait_q();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic model_step_ptr();
        if (AUTOINC) model_ptr = (model_ptr + 1) % NUM_REGS;
    endtask

    task automatic bus_write_txn(input logic [7:0] ptr, input int n);
        logic ack;
        int   base;
        int   exp_addr [8];
        base = wr_cnt;
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        check_val("wr_addr_ack", 32'(ack), 32'd1);
        write_byte(ptr, ack);
        check_val("wr_ptr_ack", 32'(ack), 32'd1);
        model_ptr = int'(ptr) % NUM_REGS;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            check_val("wr_data_ack", 32'(ack), 32'd1);
            exp_addr[i] = model_ptr;
            model_regs[model_ptr] = wbuf[i];
            model_step_ptr();
        end
        i2c_stop();
        repeat (4 * Q) @(negedge clk);
        check_val("wr_pulse_count", 32'(wr_cnt - base), 32'(n));
        check_val("wr_busy_stop", 32'(busy), 32'd0);
        for (int i = 0; i < n; i++) begin
            check_val("wr_pulse_addr", 32'(cap_addr[(base + i) % 256]), 32'(exp_addr[i]));
            check_val("wr_pulse_data", 32'(cap_data[(base + i) % 256]), 32'(wbuf[i]));
        end
    endtask

    task automatic bus_read_txn(input logic set_ptr, input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_v;
        if (set_ptr) begin
            i2c_start();
            write_byte({DEV, 1'b0}, ack);
            check_val("rd_waddr_ack", 32'(ack), 32'd1);
            write_byte(ptr, ack);
            check_val("rd_ptr_ack", 32'(ack), 32'd1);
            model_ptr = int'(ptr) % NUM_REGS;
        end
        i2c_start();
        write_byte({DEV, 1'b1}, ack);
        check_val("rd_addr_ack", 32'(ack), 32'd1);
        check_val("rd_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            exp_v = model_regs[model_ptr];
            read_byte(d, i != n - 1);
            check_val("rd_data", 32'(d), 32'(exp_v));
            rbuf[i] = d;
            model_step_ptr();
        end
        i2c_stop();
        repeat (4 * Q) @(negedge clk);
        check_val("rd_busy_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        logic [7:0] exp_v;
        int         base;
        int         oe0;
        int         nw;
        logic [7:0] wptr;

        rst = 1'b1; scl_in = 1'b1; m_sda_low = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        repeat (5) @(negedge clk);
        check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wr_valid", 32'(bus_wr_valid), 32'd0);
        check_val("rst_wr_addr", 32'(bus_wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(bus_wr_data), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Pointer write, repeated START, two-byte read
        host_write(5'h14, 8'hA5);
        host_write(5'h15, 8'h3C);
        bus_read_txn(1'b1, 8'h14, 2);
        check_val("t1_byte0", 32'(rbuf[0]), 32'hA5);
        check_val("t1_byte1", 32'(rbuf[1]), AUTOINC ? 32'h3C : 32'hA5);

        // Data write across the top of the register file
        base = wr_cnt;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        bus_write_txn(8'h1F, 2);
        check_val("wrap_addr0", 32'(cap_addr[base % 256]), 32'h1F);
        check_val("wrap_addr1", 32'(cap_addr[(base + 1) % 256]), AUTOINC ? 32'h00 : 32'h1F);
        bus_read_txn(1'b1, 8'h1F, 1);
        check_val("wrap_rd_1f", 32'(rbuf[0]), AUTOINC ? 32'h11 : 32'h22);
        bus_read_txn(1'b1, 8'h00, 1);
        check_val("wrap_rd_00", 32'(rbuf[0]), AUTOINC ? 32'h22 : 32'h00);

        // Foreign address: target must stay off the bus
        oe0 = oe_cnt; base = wr_cnt;
        i2c_start();
        write_byte({7'h30, 1'b0}, ack);
        check_val("bad_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h05, ack);
        write_byte(8'h77, ack);
        check_val("bad_addr_busy", 32'(busy), 32'd0);
        i2c_stop();
        repeat (4 * Q) @(negedge clk);
        check_val("bad_addr_oe", 32'(oe_cnt - oe0), 32'd0);
        check_val("bad_addr_pulses", 32'(wr_cnt - base), 32'd0);
        bus_read_txn(1'b1, 8'h05, 1);

        // Host overwrite in the middle of a read byte
        host_write(5'h14, 8'hA5);
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        check_val("snap_waddr_ack", 32'(ack), 32'd1);
        write_byte(8'h14, ack);
        check_val("snap_ptr_ack", 32'(ack), 32'd1);
        model_ptr = 8'h14;
        i2c_start();
        write_byte({DEV, 1'b1}, ack);
        check_val("snap_raddr_ack", 32'(ack), 32'd1);
        exp_v = model_regs[model_ptr];
        fork
            read_byte(d, 1'b0);
            begin
                repeat (16 * Q) @(negedge clk);
                host_write(5'h14, 8'hFF);
            end
        join
        check_val("snap_byte", 32'(d), 32'(exp_v));
        check_val("snap_byte_a5", 32'(d), 32'hA5);
        model_step_ptr();
        i2c_stop();
        repeat (4 * Q) @(negedge clk);
        bus_read_txn(1'b1, 8'h14, 1);
        check_val("snap_next_ff", 32'(rbuf[0]), 32'hFF);

        // Host and bus write the same register in the same clock
        model_regs[5] = 8'h01;
        wbuf[0] = 8'h02;
        host_addr = 5'h05; host_wdata = 8'h01; host_we = 1'b1;
        fork
            bus_write_txn(8'h05, 1);
            begin
                bit hit;
                hit = 1'b0;
                for (int k = 0; k < 4000 && !hit; k++) begin
                    @(negedge clk);
                    if (bus_wr_valid) hit = 1'b1;
                end
                @(posedge clk);
                #1 host_we = 1'b0;
                check_val("collide_seen", 32'(hit), 32'd1);
            end
        join
        bus_read_txn(1'b1, 8'h05, 1);
        check_val("collide_bus_wins", 32'(rbuf[0]), 32'h02);

        // Reset in the middle of a read byte
        host_write(5'h0A, 8'hA5);
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h0A, ack);
        i2c_start();
        write_byte({DEV, 1'b1}, ack);
        for (int i = 0; i < 4; i++) read_bit(b);
        check_val("pre_rst_oe", 32'(sda_oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_async_oe", 32'(sda_oe), 32'd0);
        check_val("rst_async_busy", 32'(busy), 32'd0);
        m_sda_low = 1'b0; wait_q();
        scl_in = 1'b1;    wait_q();
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        repeat (4 * Q) @(negedge clk);
        bus_read_txn(1'b0, 8'h00, 1);
        check_val("post_rst_rd", 32'(rbuf[0]), 32'h00);

        // Randomized host loads, bus writes and reads
        for (int it = 0; it < 6; it++) begin
            host_write(5'($urandom_range(0, 31)), 8'($urandom));
            host_write(5'($urandom_range(0, 31)), 8'($urandom));
            nw = int'($urandom_range(1, 3));
            for (int j = 0; j < nw; j++) wbuf[j] = 8'($urandom);
            wptr = 8'($urandom);
            bus_write_txn(wptr, nw);
            if (it % 2 == 0) begin
                bus_read_txn(1'b1, wptr, int'($urandom_range(1, 3)));
            end else begin
                bus_read_txn(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (slave) that answers the team's 2-byte register-read master; the sensor-side end of the same bus.
- Holds a small byte register file loaded from fabric (e.g. emulated color-sensor channel data). Serves pointer writes, data writes and multi-byte reads with repeated START.
- Used as an on-chip sensor stand-in and as the bus model in master testbenches.

Parameters:
- DEV_ADDR, 7'h29, 7-bit target address matched after START.
- NUM_REGS, 32, register file depth in bytes; must equal 2**ADDR_W.
- ADDR_W, 5, register pointer width.

Ports:
- clk  in  1  system clock; at least 8x the SCL rate.
- rst  in  1  reset.
- scl_in  in  1  SCL pad input (asynchronous).
- sda_in  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low, 0 = release (pad is open-drain).
- host_we  in  1  fabric write strobe to the register file.
- host_addr  in  ADDR_W  fabric write address.
- host_wdata  in  8  fabric write data.
- bus_wr_valid  out  1  one-clk pulse when the I2C master writes a data byte.
- bus_wr_addr  out  ADDR_W  register written by the bus; valid with the pulse.
- bus_wr_data  out  8  byte written by the bus; valid with the pulse.
- busy  out  1  high from an address-matched ACK until STOP or a mismatched repeated START.

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All logic is on posedge clk.
- Reset values: sda_oe=0, busy=0, bus_wr_valid=0, bus_wr_addr=0, bus_wr_data=0, pointer=0, state=IDLE, register file all 8'h00.
- Input sync: scl_in and sda_in each pass through 2 flops plus 1 history flop. All edge and condition detection uses the synced values.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bit timing:
  - Sample SDA on a synced SCL rising edge.
  - Change sda_oe only on a synced SCL falling edge, so SDA never changes while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- IDLE: START -> ADDR, bit counter = 7.
- ADDR: shift in 8 bits MSB first. After bit 0:
  - upper 7 bits == DEV_ADDR: drive ACK (sda_oe=1) on the next SCL fall, set busy -> ADDR_ACK.
  - otherwise -> IDLE, never driving SDA.
- ADDR_ACK: on the SCL fall that ends the ACK bit:
  - R/W=0: release SDA -> PTR.
  - R/W=1: load the read shift register from reg[pointer], drive bit 7 (sda_oe = ~bit) -> RDATA.
- PTR: receive 8 bits. pointer = byte[ADDR_W-1:0] (upper bits ignored, wraps mod NUM_REGS). ACK -> PTR_ACK -> WDATA.
- WDATA: receive 8 bits, then:
  - reg[pointer] = byte.
  - bus_wr_valid pulses 1 clk, with bus_wr_addr = pointer and bus_wr_data = byte.
  - pointer increments with wrap.
  - ACK -> WDATA_ACK -> WDATA.
- RDATA: shift out 8 bits, each bit driven on an SCL fall. After the 8th bit, release SDA -> RACK.
- RACK: sample the master's bit on the SCL rise.
  - ACK (0): pointer increments; on the SCL fall load reg[pointer] and drive its bit 7 -> RDATA.
  - NACK (1): pointer increments, SDA stays released -> IDLE.
  - busy stays 1 until STOP.
- Read data is snapshotted when the shift register loads; host writes during a byte do not corrupt it.
- START in any state (repeated START): release SDA, pointer unchanged -> ADDR.
- STOP in any state: release SDA, busy=0 -> IDLE.
- Simultaneous host_we and bus write in the same clk:
  - same address: bus write wins.
  - different addresses: both writes happen.
- Reset mid-transfer: sda_oe drops to 0 asynchronously. Nothing on the bus is driven until the next matching START.
- Latency: sda_oe updates 3–4 clk after the SCL falling edge at the pad.

Optional Feature:
- Macro: I2C_TGT_AUTOINC_EN.
- Defined: the pointer auto-increments after each data byte, written or read, as described above.
- Not defined: the pointer changes only on a PTR write. Consecutive reads and writes all target the same register.

Test Plan:
- Host loads reg[0x14]=8'hA5, reg[0x15]=8'h3C. Bus does W 0x29, ptr 0x14, Sr, R 0x29, 2 bytes (ACK, then NACK), STOP -> master receives A5 then 3C; all three address/pointer ACKs seen; busy falls at STOP.
- Bus write 0x29, ptr 0x1F, data 11, 22 -> bus_wr_valid pulses twice (addr 1F data 11, then addr 00 data 22, showing the wrap). Readback of reg[0x1F] and reg[0x00] matches.
- Address 0x30 with a write -> SDA never driven (sda_oe stays 0 for the whole transfer); busy stays 0; register file unchanged.
- Host writes reg[0x14]=8'hFF mid-byte during the read of reg[0x14]=8'hA5 -> bus byte is A5; the next read of 0x14 returns FF.
- Host and bus write address 0x05 in the same clk (host 8'h01, bus 8'h02) -> reg[0x05]=8'h02.
- rst asserted after 4 data bits of a read byte -> sda_oe=0 the same cycle. A new full transaction after rst release reads 8'h00 from pointer 0.
- Without I2C_TGT_AUTOINC_EN: 2-byte read at 0x14 -> A5, A5.
